// File: rtl/instruction_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
package instruction_fetch_queue_pkg;
  localparam int INSTR_W = 16;
  localparam int BYTE_W  = 8;
  localparam int ADDR_W  = 16;
  localparam logic [ADDR_W-1:0] PC_STEP = 16'd2;

  typedef enum logic [1:0] {IDLE, RD_HI, RD_LO, CAPTURE} fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fq_entry_t;
endpackage

// File: rtl/instruction_fetch_queue_fetch_fifo.sv
// DEPTH-entry synchronous FIFO with flush; flush wins over push/pop.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);
  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]           count_q;
  logic                    do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointers are exactly log2(DEPTH) wide, so increments wrap on their own.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/instruction_fetch_queue.sv
// Fetches big-endian 16-bit instructions from byte memory into a prefetch
// queue; redirect flushes the queue and restarts fetch at the new PC.
module instruction_fetch_queue
  import instruction_fetch_queue_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_addr,
  output logic               mem_rd,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [BYTE_W-1:0]  mem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready
);
  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [BYTE_W-1:0] hi_byte_q, hi_byte_d;
  fq_entry_t         push_entry, head_entry;
  logic              push, pop, full, empty;
  logic [CW-1:0]     count, post_cnt;

  assign pop        = instr_valid && instr_ready;
  assign push       = (state_q == CAPTURE);
  assign push_entry = '{pc: fetch_pc_q, instr: {hi_byte_q, mem_rdata}};
  assign post_cnt   = count + CW'(1) - CW'(pop);

  // Redirect drives flush, which the FIFO prioritises over the CAPTURE push.
  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(fq_entry_t)),
    .CW    (CW)
  ) u_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .flush_i (redirect),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (push_entry),
    .rdata_o (head_entry),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  assign instr_valid = !empty;
  assign instr       = head_entry.instr;
  assign instr_pc    = head_entry.pc;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    hi_byte_d  = hi_byte_q;
    mem_rd     = 1'b0;
    mem_addr   = fetch_pc_q;
    case (state_q)
      IDLE:    if (!full) state_d = RD_HI;
      RD_HI: begin
        mem_rd  = 1'b1;
        state_d = RD_LO;
      end
      RD_LO: begin
        mem_rd    = 1'b1;
        mem_addr  = fetch_pc_q + ADDR_W'(1);
        hi_byte_d = mem_rdata;
        state_d   = CAPTURE;
      end
      CAPTURE: begin
        // Slot for the next fetch is reserved here, counting this push.
        fetch_pc_d = fetch_pc_q + PC_STEP;
        state_d    = (post_cnt < CW'(DEPTH)) ? RD_HI : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (redirect) begin
      state_d    = RD_HI;
      fetch_pc_d = redirect_addr & ~ADDR_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      hi_byte_q  <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      hi_byte_q  <= hi_byte_d;
    end
  end
endmodule
